// File: rtl/fp16_pkg.sv
// Shared FP16 constants and the FSM state encoding used by the lib_fp multi-cycle resources.
package fp16_pkg;

   localparam int FP16_EXP_W   = 5;
   localparam int FP16_FRAC_W  = 10;
   localparam int FP16_BIAS    = (2 ** (FP16_EXP_W - 1)) - 1;
   localparam int FP16_EXP_MAX = (2 ** FP16_EXP_W) - 1;

   localparam logic [15:0] FP16_QNAN = 16'h7E00;
   localparam logic [15:0] FP16_INF  = 16'h7C00;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      PACK = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/fp16_classify.sv
// Splits an FP16 word into sign/exponent/mantissa and flags zero (subnormals flushed) and infinity (NaN folded in).
module fp16_classify
   import fp16_pkg::*;
(
   input  logic [15:0] i_val,
   output logic        o_sign,
   output logic [4:0]  o_exp,
   output logic [10:0] o_mant,
   output logic        o_is_zero,
   output logic        o_is_inf
);

   assign o_sign    = i_val[15];
   assign o_exp     = i_val[14:10];
   assign o_mant    = {1'b1, i_val[9:0]};
   assign o_is_zero = (i_val[14:10] == 5'd0);
   assign o_is_inf  = (i_val[14:10] == 5'(FP16_EXP_MAX));

endmodule

// File: rtl/fp16_iter_div.sv
// Iterative FP16 divider: restoring radix-2 mantissa division, fixed 13-cycle latency, valid/ready on both sides.
module fp16_iter_div
   import fp16_pkg::*;
#(
   parameter int EXP_W  = FP16_EXP_W,
   parameter int FRAC_W = FP16_FRAC_W,
   parameter int BIAS   = (2 ** (EXP_W - 1)) - 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    arg_valid,
   output logic                    arg_ready,
   input  logic [EXP_W+FRAC_W:0]   arg_0,
   input  logic [EXP_W+FRAC_W:0]   arg_1,
   output logic                    ret_valid,
   input  logic                    ret_ready,
   output logic [EXP_W+FRAC_W:0]   ret_0
);

   logic        w_xs, w_ys, w_xz, w_yz, w_xi, w_yi;
   logic [4:0]  w_xe, w_ye;
   logic [10:0] w_xm, w_ym;

   fp16_classify u_cls_x (
      .i_val(arg_0), .o_sign(w_xs), .o_exp(w_xe), .o_mant(w_xm),
      .o_is_zero(w_xz), .o_is_inf(w_xi)
   );

   fp16_classify u_cls_y (
      .i_val(arg_1), .o_sign(w_ys), .o_exp(w_ye), .o_mant(w_ym),
      .o_is_zero(w_yz), .o_is_inf(w_yi)
   );

   state_t      r_state;
   logic        r_arg_ready, r_ret_valid;
   logic [15:0] r_ret_0;
   logic [3:0]  r_cnt;
   logic [11:0] r_rem, r_quo;
   logic [10:0] r_ym;
   logic [4:0]  r_xe, r_ye;
   logic        r_sign, r_xz, r_yz, r_xi, r_yi;

   logic              w_accept, w_ge;
   logic [11:0]       w_rem_sub;
   logic signed [6:0] w_exp;
   logic [9:0]        w_frac;
   logic [15:0]       w_result;

   assign w_accept  = arg_valid && r_arg_ready && (r_state == IDLE);
   assign w_ge      = (r_rem >= {1'b0, r_ym});
   assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_ym}) : r_rem;

   // A leading quotient bit means mx >= my: take one more fraction bit and one more exponent step.
   assign w_exp  = $signed({2'b00, r_xe}) - $signed({2'b00, r_ye})
                 + (r_quo[11] ? 7'(BIAS) : 7'(BIAS - 1));
   assign w_frac = r_quo[11] ? r_quo[10:1] : r_quo[9:0];

   always_comb begin
      w_result = {r_sign, 15'h0};
      if ((r_xz && r_yz) || (r_xi && r_yi))
         w_result = FP16_QNAN;
      else if (r_yz || r_xi)
         w_result = {r_sign, FP16_INF[14:0]};
      else if (r_xz || r_yi)
         w_result = {r_sign, 15'h0};
      else if (w_exp <= 7'sd0)
         w_result = {r_sign, 15'h0};
      else if (w_exp >= 7'(FP16_EXP_MAX))
         w_result = {r_sign, FP16_INF[14:0]};
      else
         w_result = {r_sign, w_exp[4:0], w_frac};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_arg_ready <= 1'b0;
         r_ret_valid <= 1'b0;
         r_ret_0     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_arg_ready <= 1'b0;
                  r_state     <= DIV;
               end else begin
                  r_arg_ready <= 1'b1;
               end
            end
            DIV:  if (r_cnt == 4'd0) r_state <= PACK;
            PACK: begin
               r_ret_0     <= w_result;
               r_ret_valid <= 1'b1;
               r_state     <= DONE;
            end
            DONE: begin
               if (ret_ready) begin
                  r_ret_valid <= 1'b0;
                  r_arg_ready <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // NOTE: the datapath has no reset; every register is loaded on accept before the FSM ever reads it.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_cnt  <= 4'd11;
         r_rem  <= {1'b0, w_xm};
         r_quo  <= '0;
         r_ym   <= w_ym;
         r_xe   <= w_xe;
         r_ye   <= w_ye;
         r_sign <= w_xs ^ w_ys;
         r_xz   <= w_xz;
         r_yz   <= w_yz;
         r_xi   <= w_xi;
         r_yi   <= w_yi;
      end else if (r_state == DIV) begin
         r_cnt <= r_cnt - 4'd1;
         r_quo <= {r_quo[10:0], w_ge};
         r_rem <= w_rem_sub << 1;
      end
   end

   assign arg_ready = r_arg_ready;
   assign ret_valid = r_ret_valid;
   assign ret_0     = r_ret_0;

endmodule

// File: tb/tb_fp16_iter_div.sv
// Directed self-checking bench for fp16_iter_div: vector table plus handshake and reset-abort sequences.
module tb_fp16_iter_div;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        arg_valid = 1'b0;
   logic        arg_ready;
   logic [15:0] arg_0 = '0;
   logic [15:0] arg_1 = '0;
   logic        ret_valid;
   logic        ret_ready = 1'b0;
   logic [15:0] ret_0;

   int n_checks = 0;
   int n_errors = 0;

   fp16_iter_div dut (
      .clk(clk), .rst(rst),
      .arg_valid(arg_valid), .arg_ready(arg_ready),
      .arg_0(arg_0), .arg_1(arg_1),
      .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_0(ret_0)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] expv;
      string       name;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits for arg_ready, issues one operation, checks latency/result, optionally stalls, then retires it.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] expv,
                         input string name, input int stall, input bit toggle);
      int guard;
      int lat;
      int ready_seen;
      guard = 0;
      while (arg_ready !== 1'b1 && guard < 100) begin
         step();
         guard++;
      end
      if (arg_ready !== 1'b1) begin
         check({name, " arg_ready timeout"}, {31'd0, arg_ready}, 32'd1);
         return;
      end
      arg_0 = a;
      arg_1 = b;
      arg_valid = 1'b1;
      step();
      arg_valid = 1'b0;
      lat = 0;
      ready_seen = 0;
      while (ret_valid !== 1'b1 && lat < 50) begin
         if (toggle) begin
            arg_valid = lat[0];
            arg_0 = 16'h0000;
            arg_1 = 16'h0000;
         end
         step();
         lat++;
         if (arg_ready !== 1'b0) ready_seen++;
      end
      arg_valid = 1'b0;
      check({name, " latency"}, lat, 32'd13);
      check({name, " busy arg_ready"}, ready_seen, 32'd0);
      if (ret_valid !== 1'b1) return;
      check({name, " result"}, {16'd0, ret_0}, {16'd0, expv});
      for (int i = 0; i < stall; i++) begin
         step();
         check({name, " stall valid"}, {31'd0, ret_valid}, 32'd1);
         check({name, " stall data"}, {16'd0, ret_0}, {16'd0, expv});
      end
      ret_ready = 1'b1;
      step();
      ret_ready = 1'b0;
      check({name, " ret_valid cleared"}, {31'd0, ret_valid}, 32'd0);
      check({name, " arg_ready back"}, {31'd0, arg_ready}, 32'd1);
   endtask

   initial begin
      int seen;

      vecs[0]  = '{16'h3C00, 16'h3C00, 16'h3C00, "1/1"};
      vecs[1]  = '{16'h3E00, 16'h3A00, 16'h4000, "1.5/0.75"};
      vecs[2]  = '{16'h3C00, 16'h4200, 16'h3555, "1/3"};
      vecs[3]  = '{16'hC000, 16'h3800, 16'hC400, "-2/0.5"};
      vecs[4]  = '{16'h0400, 16'h4000, 16'h0000, "underflow"};
      vecs[5]  = '{16'h7800, 16'h0400, 16'h7C00, "overflow"};
      vecs[6]  = '{16'h3C00, 16'h0000, 16'h7C00, "x/0"};
      vecs[7]  = '{16'h0000, 16'h0000, 16'h7E00, "0/0"};
      vecs[8]  = '{16'h0200, 16'h3C00, 16'h0000, "subnormal"};
      vecs[9]  = '{16'h7C00, 16'hFC00, 16'h7E00, "inf/inf"};
      vecs[10] = '{16'hBC00, 16'h7C00, 16'h8000, "-1/inf"};
      vecs[11] = '{16'h4500, 16'h8000, 16'hFC00, "5/-0"};
      vecs[12] = '{16'h7E01, 16'h3C00, 16'h7C00, "nan/1"};

      // Reset state
      repeat (3) step();
      check("reset arg_ready", {31'd0, arg_ready}, 32'd0);
      check("reset ret_valid", {31'd0, ret_valid}, 32'd0);
      check("reset ret_0", {16'd0, ret_0}, 32'd0);
      rst = 1'b1;
      step();
      check("first edge arg_ready", {31'd0, arg_ready}, 32'd1);

      // ret_ready with nothing pending must not disturb the idle divider
      ret_ready = 1'b1;
      repeat (3) step();
      ret_ready = 1'b0;
      check("idle ret_ready valid", {31'd0, ret_valid}, 32'd0);
      check("idle ret_ready ready", {31'd0, arg_ready}, 32'd1);

      for (int i = 0; i < 13; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].expv, vecs[i].name, 0, 1'b0);

      run_op(16'h3C00, 16'h4200, 16'h3555, "stall5", 5, 1'b0);
      run_op(16'hC000, 16'h3800, 16'hC400, "busy toggle", 0, 1'b1);

      // Abort mid-DIV: rst sampled low at the edge where cnt==5 (accept edge + 7)
      seen = 0;
      while (arg_ready !== 1'b1 && seen < 100) begin
         step();
         seen++;
      end
      arg_0 = 16'h3C00;
      arg_1 = 16'h3C00;
      arg_valid = 1'b1;
      step();
      arg_valid = 1'b0;
      repeat (6) step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      check("abort ret_valid", {31'd0, ret_valid}, 32'd0);
      check("abort arg_ready", {31'd0, arg_ready}, 32'd0);
      step();
      check("abort arg_ready recovers", {31'd0, arg_ready}, 32'd1);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (ret_valid !== 1'b0) seen++;
      end
      check("abort no ret_valid", seen, 32'd0);

      run_op(16'h3E00, 16'h3A00, 16'h4000, "after abort", 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
